// File: rtl/regfile_write_arbiter_pkg.sv
// ----------------------------------------------------------------------------
// regfile_write_arbiter_pkg
//   Shared definitions for the register-file write-port arbiter.
//   - RF_ARB_MAX_WAIT : default number of cycles B may lose before it is forced
//   - RF_ARB_REQ_A/B  : requester encodings used to select the winning slot
//   - slot_state_e    : holding-slot state codes (EMPTY / FULL)
//   - sat_inc16       : saturating 16-bit increment for the optional statistics
// ----------------------------------------------------------------------------
package regfile_write_arbiter_pkg;

   localparam int   RF_ARB_MAX_WAIT = 4;

   localparam logic RF_ARB_REQ_A    = 1'b0;
   localparam logic RF_ARB_REQ_B    = 1'b1;

   typedef enum logic {
      SLOT_EMPTY = 1'b0,
      SLOT_FULL  = 1'b1
   } slot_state_e;

   function automatic logic [15:0] sat_inc16(input logic [15:0] value);
      return (value == 16'hFFFF) ? value : value + 16'd1;
   endfunction

endpackage

// File: rtl/regfile_write_arbiter_slot.sv
// ----------------------------------------------------------------------------
// regfile_write_arbiter_slot  (the rf_arb_slot holding slot)
//   One-entry holding register for a single write producer.
//   Handshake: a write is taken on a clock edge where valid && ready. ready is
//   high while the slot is EMPTY, or while it is FULL and being granted this
//   cycle, so a producer can stream one write per cycle behind its own grants.
//   Ports:
//     clk, rst          clock, synchronous active-high reset
//     valid/dest/data   producer request
//     ready             slot can accept this cycle (combinational)
//     grant             arbiter is draining this slot this cycle
//     state             slot FSM state (EMPTY / FULL)
//     slot_dest/data    held write
// ----------------------------------------------------------------------------
module regfile_write_arbiter_slot
   import regfile_write_arbiter_pkg::*;
#(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 5
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              valid,
   input  logic [ADDR_W-1:0] dest,
   input  logic [DATA_W-1:0] data,
   output logic              ready,
   input  logic              grant,
   output slot_state_e       state,
   output logic [ADDR_W-1:0] slot_dest,
   output logic [DATA_W-1:0] slot_data
);

   assign ready = (state == SLOT_EMPTY) || grant;

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= SLOT_EMPTY;
         slot_dest <= '0;
         slot_data <= '0;
      end else begin
         case (state)
            SLOT_EMPTY: begin
               if (valid) begin
                  state     <= SLOT_FULL;
                  slot_dest <= dest;
                  slot_data <= data;
               end
            end
            SLOT_FULL: begin
               if (grant) begin
                  // A refill in the same cycle as the drain keeps the slot FULL.
                  if (valid) begin
                     slot_dest <= dest;
                     slot_data <= data;
                  end else begin
                     state <= SLOT_EMPTY;
                  end
               end
            end
            default: state <= SLOT_EMPTY;
         endcase
      end
   end

endmodule

// File: rtl/regfile_write_arbiter.sv
// ----------------------------------------------------------------------------
// regfile_write_arbiter
//   Shares the single register-file write port between producer A (pipeline
//   writeback, primary) and producer B (multi-cycle unit). Each producer owns a
//   one-entry holding slot. A wins by default; B is forced through after it has
//   lost MAX_WAIT consecutive cycles while full (aging, disabled if MAX_WAIT=0).
//   Ports:
//     clk, rst                      clock, synchronous active-high reset
//     a_valid/a_dest/a_data/a_ready producer A request + ready
//     b_valid/b_dest/b_data/b_ready producer B request + ready
//     rf_writeEn/rf_dest/rf_writeVal registered write port to the regfile
//     q_src1/q_src2                 hazard query addresses
//     q_hit1/q_hit2                 a write to that address is still pending
//   Optional (RF_ARB_STATS_EN defined):
//     stat_grant_a, stat_grant_b    saturating grant counters
//     stat_conflict                 saturating count of cycles both slots FULL
// ----------------------------------------------------------------------------
module regfile_write_arbiter
   import regfile_write_arbiter_pkg::*;
#(
   parameter int DATA_W   = 32,
   parameter int ADDR_W   = 5,
   parameter int MAX_WAIT = RF_ARB_MAX_WAIT,
   parameter int CNT_W    = 3
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              a_valid,
   input  logic [ADDR_W-1:0] a_dest,
   input  logic [DATA_W-1:0] a_data,
   output logic              a_ready,
   input  logic              b_valid,
   input  logic [ADDR_W-1:0] b_dest,
   input  logic [DATA_W-1:0] b_data,
   output logic              b_ready,
   output logic              rf_writeEn,
   output logic [ADDR_W-1:0] rf_dest,
   output logic [DATA_W-1:0] rf_writeVal,
   input  logic [ADDR_W-1:0] q_src1,
   input  logic [ADDR_W-1:0] q_src2,
   output logic              q_hit1,
   output logic              q_hit2
`ifdef RF_ARB_STATS_EN
   ,
   output logic [15:0]       stat_grant_a,
   output logic [15:0]       stat_grant_b,
   output logic [15:0]       stat_conflict
`endif
);

   localparam logic [CNT_W-1:0] WAIT_LIMIT = CNT_W'(MAX_WAIT);
   localparam logic             AGING_EN   = (MAX_WAIT != 0);

   slot_state_e       a_state, b_state;
   logic [ADDR_W-1:0] a_slot_dest, b_slot_dest;
   logic [DATA_W-1:0] a_slot_data, b_slot_data;
   logic              a_full, b_full;
   logic              grant_a, grant_b;
   logic              win_req;
   logic [ADDR_W-1:0] win_dest;
   logic [DATA_W-1:0] win_data;
   logic [CNT_W-1:0]  wait_b;

   // ---------------------------------------------------------------- slots
   regfile_write_arbiter_slot #(
      .DATA_W (DATA_W),
      .ADDR_W (ADDR_W)
   ) u_slot_a (
      .clk       (clk),
      .rst       (rst),
      .valid     (a_valid),
      .dest      (a_dest),
      .data      (a_data),
      .ready     (a_ready),
      .grant     (grant_a),
      .state     (a_state),
      .slot_dest (a_slot_dest),
      .slot_data (a_slot_data)
   );

   regfile_write_arbiter_slot #(
      .DATA_W (DATA_W),
      .ADDR_W (ADDR_W)
   ) u_slot_b (
      .clk       (clk),
      .rst       (rst),
      .valid     (b_valid),
      .dest      (b_dest),
      .data      (b_data),
      .ready     (b_ready),
      .grant     (grant_b),
      .state     (b_state),
      .slot_dest (b_slot_dest),
      .slot_data (b_slot_data)
   );

   assign a_full = (a_state == SLOT_FULL);
   assign b_full = (b_state == SLOT_FULL);

   // ---------------------------------------------------------------- grant
   // B only wins when A has nothing, or when B has aged out. One grant max.
   always_comb begin
      grant_b = b_full && (!a_full || (AGING_EN && (wait_b == WAIT_LIMIT)));
      grant_a = a_full && !grant_b;
   end

   always_comb begin
      win_req  = grant_b ? RF_ARB_REQ_B : RF_ARB_REQ_A;
      win_dest = (win_req == RF_ARB_REQ_B) ? b_slot_dest : a_slot_dest;
      win_data = (win_req == RF_ARB_REQ_B) ? b_slot_data : a_slot_data;
   end

   // ---------------------------------------------------------------- aging
   always_ff @(posedge clk) begin
      if (rst) begin
         wait_b <= '0;
      end else if (!b_full || grant_b) begin
         wait_b <= '0;
      end else if (wait_b != WAIT_LIMIT) begin
         wait_b <= wait_b + 1'b1;
      end
   end

   // ---------------------------------------------------------------- output
   // A write to r0 still consumes its grant but never raises the enable.
   always_ff @(posedge clk) begin
      if (rst) begin
         rf_writeEn  <= 1'b0;
         rf_dest     <= '0;
         rf_writeVal <= '0;
      end else if (grant_a || grant_b) begin
         rf_writeEn  <= (win_dest != '0);
         rf_dest     <= win_dest;
         rf_writeVal <= win_data;
      end else begin
         rf_writeEn  <= 1'b0;
      end
   end

   // ---------------------------------------------------------------- query
   function automatic logic pending(
      input logic [ADDR_W-1:0] src,
      input logic              af,
      input logic [ADDR_W-1:0] ad,
      input logic              bf,
      input logic [ADDR_W-1:0] bd,
      input logic              oe,
      input logic [ADDR_W-1:0] od
   );
      return (src != '0) &&
             ((af && (ad == src)) || (bf && (bd == src)) || (oe && (od == src)));
   endfunction

   assign q_hit1 = pending(q_src1, a_full, a_slot_dest, b_full, b_slot_dest,
                           rf_writeEn, rf_dest);
   assign q_hit2 = pending(q_src2, a_full, a_slot_dest, b_full, b_slot_dest,
                           rf_writeEn, rf_dest);

   // ---------------------------------------------------------------- stats
`ifdef RF_ARB_STATS_EN
   always_ff @(posedge clk) begin
      if (rst) begin
         stat_grant_a  <= '0;
         stat_grant_b  <= '0;
         stat_conflict <= '0;
      end else begin
         if (grant_a)          stat_grant_a  <= sat_inc16(stat_grant_a);
         if (grant_b)          stat_grant_b  <= sat_inc16(stat_grant_b);
         if (a_full && b_full) stat_conflict <= sat_inc16(stat_conflict);
      end
   end
`endif

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// ----------------------------------------------------------------------------
// tb_regfile_write_arbiter
//   Directed scenarios plus a randomized run against a queue-based reference
//   model of the two holding slots and the write port. Build with
//   RF_ARB_STATS_EN defined to also cover the statistics counters.
// ----------------------------------------------------------------------------
module tb_regfile_write_arbiter;

   localparam int DW = 32;
   localparam int AW = 5;
   localparam int MW = 4;

   // ------------------------------------------------------------ clock/reset
   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic          rst;
   logic          a_valid, b_valid;
   logic [AW-1:0] a_dest, b_dest;
   logic [DW-1:0] a_data, b_data;
   logic          a_ready, b_ready;
   logic          rf_writeEn;
   logic [AW-1:0] rf_dest;
   logic [DW-1:0] rf_writeVal;
   logic [AW-1:0] q_src1, q_src2;
   logic          q_hit1, q_hit2;
`ifdef RF_ARB_STATS_EN
   logic [15:0]   stat_grant_a, stat_grant_b, stat_conflict;
`endif

   regfile_write_arbiter dut (
      .clk         (clk),
      .rst         (rst),
      .a_valid     (a_valid),
      .a_dest      (a_dest),
      .a_data      (a_data),
      .a_ready     (a_ready),
      .b_valid     (b_valid),
      .b_dest      (b_dest),
      .b_data      (b_data),
      .b_ready     (b_ready),
      .rf_writeEn  (rf_writeEn),
      .rf_dest     (rf_dest),
      .rf_writeVal (rf_writeVal),
      .q_src1      (q_src1),
      .q_src2      (q_src2),
      .q_hit1      (q_hit1),
      .q_hit2      (q_hit2)
`ifdef RF_ARB_STATS_EN
      ,
      .stat_grant_a  (stat_grant_a),
      .stat_grant_b  (stat_grant_b),
      .stat_conflict (stat_conflict)
`endif
   );

   int n_cmp = 0;
   int n_bad = 0;

   // ------------------------------------------------------------ reference model
   // Each slot is a queue holding at most one {dest,data} entry.
   logic [AW+DW-1:0] a_q[$];
   logic [AW+DW-1:0] b_q[$];
   logic [AW+DW-1:0] exp_q[$];   // write expected on the port right now
   int               wait_m;
   logic             m_en;
   logic [AW-1:0]    m_dest;
   logic [DW-1:0]    m_val;
   int               gnt;        // 0 none, 1 A, 2 B
   logic             m_af, m_bf;
   logic [AW+DW-1:0] m_ah, m_bh;
   logic             e_a_rdy, e_b_rdy, e_hit1, e_hit2;
   int               st_a, st_b, st_c;

   function automatic logic [AW-1:0] dest_of(input logic [AW+DW-1:0] e);
      return e[AW+DW-1:DW];
   endfunction

   function automatic logic [DW-1:0] data_of(input logic [AW+DW-1:0] e);
      return e[DW-1:0];
   endfunction

   function automatic logic hit_of(input logic [AW-1:0] src);
      return (src != 0) &&
             ((m_af && dest_of(m_ah) == src) || (m_bf && dest_of(m_bh) == src) ||
              (m_en && m_dest == src));
   endfunction

   task automatic settle;
      #1;
      m_af = (a_q.size() != 0);
      m_bf = (b_q.size() != 0);
      m_ah = m_af ? a_q[0] : '0;
      m_bh = m_bf ? b_q[0] : '0;
      if (m_bf && (!m_af || (MW != 0 && wait_m == MW))) gnt = 2;
      else if (m_af)                                      gnt = 1;
      else                                                gnt = 0;
      e_a_rdy = !m_af || (gnt == 1);
      e_b_rdy = !m_bf || (gnt == 2);
      e_hit1  = hit_of(q_src1);
      e_hit2  = hit_of(q_src2);
   endtask

   task automatic clock_edge;
      settle();
      @(posedge clk);
      if (rst) begin
         a_q.delete(); b_q.delete(); exp_q.delete();
         wait_m = 0; m_en = 1'b0; m_dest = '0; m_val = '0;
         st_a = 0; st_b = 0; st_c = 0;
      end else begin
         exp_q.delete();
         if (m_af && m_bf && st_c < 65535) st_c++;
         m_en = 1'b0;
         if (gnt == 1) begin
            m_dest = dest_of(m_ah); m_val = data_of(m_ah); m_en = (m_dest != 0);
            void'(a_q.pop_front());
            if (st_a < 65535) st_a++;
         end
         if (gnt == 2) begin
            m_dest = dest_of(m_bh); m_val = data_of(m_bh); m_en = (m_dest != 0);
            void'(b_q.pop_front());
            if (st_b < 65535) st_b++;
         end
         if (gnt == 2 || !m_bf) wait_m = 0;
         else if (wait_m < MW)  wait_m++;
         if (m_en) exp_q.push_back({m_dest, m_val});
         if (a_valid && e_a_rdy) a_q.push_back({a_dest, a_data});
         if (b_valid && e_b_rdy) b_q.push_back({b_dest, b_data});
      end
      @(negedge clk);
   endtask

   task automatic idle_inputs;
      a_valid = 1'b0; b_valid = 1'b0;
      a_dest = '0; b_dest = '0; a_data = '0; b_data = '0;
   endtask

   // ------------------------------------------------------------ scenarios
   task automatic test_reset;
      rst = 1'b1; idle_inputs();
      a_valid = 1'b1; a_dest = 5'd7; a_data = 32'hDEAD;
      q_src1 = 5'd7; q_src2 = 5'd0;
      for (int i = 0; i < 2; i++) begin
         clock_edge();
         #1;
         n_cmp++;
         if (rf_writeEn !== 1'b0 || a_ready !== 1'b1 || q_hit1 !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_outputs[%0d]: en=%b a_ready=%b hit1=%b, required 0/1/0",
                     i, rf_writeEn, a_ready, q_hit1);
         end
      end
      n_cmp++;
      if (rf_dest !== '0 || rf_writeVal !== '0) begin
         n_bad++;
         $display("FAIL reset_regs: dest=%0d val=%h, required 0/0", rf_dest, rf_writeVal);
      end
      rst = 1'b0; idle_inputs();
      clock_edge();
   endtask

   task automatic test_a_only;
      a_valid = 1'b1; a_dest = 5'd3; a_data = 32'h11; q_src1 = 5'd3;
      settle();
      n_cmp++;
      if (a_ready !== 1'b1) begin
         n_bad++; $display("FAIL a_only_ready: got %b, required 1", a_ready);
      end
      clock_edge();                 // edge N: accepted
      a_valid = 1'b0;
      settle();
      n_cmp++;
      if (q_hit1 !== 1'b1 || rf_writeEn !== 1'b0) begin
         n_bad++; $display("FAIL a_only_slot: hit1=%b en=%b, required 1/0", q_hit1, rf_writeEn);
      end
      clock_edge();                 // edge N+1: written
      #1;
      n_cmp++;
      if (rf_writeEn !== 1'b1 || rf_dest !== 5'd3 || rf_writeVal !== 32'h11 || q_hit1 !== 1'b1) begin
         n_bad++;
         $display("FAIL a_only_write: en=%b dest=%0d val=%h hit1=%b, required 1/3/11/1",
                  rf_writeEn, rf_dest, rf_writeVal, q_hit1);
      end
      clock_edge();
      #1;
      n_cmp++;
      if (rf_writeEn !== 1'b0 || q_hit1 !== 1'b0 || rf_dest !== 5'd3) begin
         n_bad++;
         $display("FAIL a_only_after: en=%b hit1=%b dest=%0d, required 0/0/3",
                  rf_writeEn, q_hit1, rf_dest);
      end
   endtask

   task automatic test_contention;
      a_valid = 1'b1; a_dest = 5'd5; a_data = 32'h55;
      b_valid = 1'b1; b_dest = 5'd6; b_data = 32'h66;
      clock_edge();                 // edge N: both accepted
      idle_inputs();
      settle();
      n_cmp++;
      if (a_ready !== 1'b1 || b_ready !== 1'b0) begin
         n_bad++; $display("FAIL contend_ready: a=%b b=%b, required 1/0", a_ready, b_ready);
      end
      clock_edge();
      #1;
      n_cmp++;
      if (rf_writeEn !== 1'b1 || rf_dest !== 5'd5 || rf_writeVal !== 32'h55) begin
         n_bad++;
         $display("FAIL contend_first: en=%b dest=%0d val=%h, required 1/5/55",
                  rf_writeEn, rf_dest, rf_writeVal);
      end
      clock_edge();
      #1;
      n_cmp++;
      if (rf_writeEn !== 1'b1 || rf_dest !== 5'd6 || rf_writeVal !== 32'h66) begin
         n_bad++;
         $display("FAIL contend_second: en=%b dest=%0d val=%h, required 1/6/66",
                  rf_writeEn, rf_dest, rf_writeVal);
      end
      clock_edge();
   endtask

   task automatic test_aging;
      a_valid = 1'b1; a_dest = 5'd2; a_data = 32'h22;
      b_valid = 1'b1; b_dest = 5'd9; b_data = 32'h99;
      clock_edge();                 // both slots filled
      b_valid = 1'b0;
      for (int i = 0; i < 5; i++) begin
         settle();
         n_cmp++;
         if (b_ready !== (i == 4)) begin
            n_bad++; $display("FAIL aging_ready[%0d]: b_ready=%b, required %b", i, b_ready, i == 4);
         end
         clock_edge();
         #1;
         n_cmp++;
         if (rf_dest !== ((i == 4) ? 5'd9 : 5'd2)) begin
            n_bad++;
            $display("FAIL aging_winner[%0d]: dest=%0d, required %0d", i, rf_dest, (i == 4) ? 9 : 2);
         end
      end
      n_cmp++;
      if (dut.wait_b !== '0) begin
         n_bad++; $display("FAIL aging_clear: wait_b=%0d, required 0", dut.wait_b);
      end
      idle_inputs();
      clock_edge();
      clock_edge();
   endtask

   task automatic test_dest_zero;
      a_valid = 1'b1; a_dest = 5'd0; a_data = 32'hFF;
      q_src1 = 5'd0; q_src2 = 5'd0;
      for (int i = 0; i < 4; i++) begin
         settle();
         n_cmp++;
         if (a_ready !== 1'b1 || q_hit1 !== 1'b0 || q_hit2 !== 1'b0) begin
            n_bad++;
            $display("FAIL zero_comb[%0d]: a_ready=%b hit1=%b hit2=%b, required 1/0/0",
                     i, a_ready, q_hit1, q_hit2);
         end
         clock_edge();
         #1;
         n_cmp++;
         if (rf_writeEn !== 1'b0) begin
            n_bad++; $display("FAIL zero_write[%0d]: en=%b, required 0", i, rf_writeEn);
         end
      end
      idle_inputs();
      clock_edge();
   endtask

   task automatic test_rst_mid;
      a_valid = 1'b1; a_dest = 5'd4; a_data = 32'h44;
      b_valid = 1'b1; b_dest = 5'd8; b_data = 32'h88;
      clock_edge();                 // both slots FULL
      idle_inputs();
      rst = 1'b1;
      clock_edge();
      rst = 1'b0;
      #1;
      n_cmp++;
      if (rf_writeEn !== 1'b0 || a_ready !== 1'b1 || b_ready !== 1'b1) begin
         n_bad++;
         $display("FAIL rst_mid: en=%b a_ready=%b b_ready=%b, required 0/1/1",
                  rf_writeEn, a_ready, b_ready);
      end
`ifdef RF_ARB_STATS_EN
      n_cmp++;
      if (stat_grant_a !== 16'd0 || stat_grant_b !== 16'd0 || stat_conflict !== 16'd0) begin
         n_bad++;
         $display("FAIL rst_mid_stats: ga=%0d gb=%0d c=%0d, required 0/0/0",
                  stat_grant_a, stat_grant_b, stat_conflict);
      end
`endif
      clock_edge();
      #1;
      n_cmp++;
      if (rf_writeEn !== 1'b0) begin
         n_bad++; $display("FAIL rst_discard: en=%b, required 0", rf_writeEn);
      end
   endtask

   task automatic test_random;
      logic [AW+DW-1:0] e;
      for (int i = 0; i < 400; i++) begin
         rst     = ($urandom_range(0, 63) == 0);
         a_valid = ($urandom_range(0, 99) < 60);
         b_valid = ($urandom_range(0, 99) < 40);
         a_dest  = AW'($urandom_range(0, 7));
         b_dest  = AW'($urandom_range(0, 7));
         a_data  = $urandom;
         b_data  = $urandom;
         q_src1  = AW'($urandom_range(0, 7));
         q_src2  = AW'($urandom_range(0, 7));
         settle();
         n_cmp++;
         if (a_ready !== e_a_rdy || b_ready !== e_b_rdy || q_hit1 !== e_hit1 || q_hit2 !== e_hit2) begin
            n_bad++;
            $display("FAIL rand_comb[%0d]: rdy=%b%b hit=%b%b, required rdy=%b%b hit=%b%b",
                     i, a_ready, b_ready, q_hit1, q_hit2, e_a_rdy, e_b_rdy, e_hit1, e_hit2);
         end
         clock_edge();
         #1;
         n_cmp++;
         if (rf_writeEn !== (exp_q.size() != 0)) begin
            n_bad++;
            $display("FAIL rand_en[%0d]: en=%b, required %b", i, rf_writeEn, exp_q.size() != 0);
         end
         if (exp_q.size() != 0) begin
            e = exp_q[0];
            n_cmp++;
            if ({rf_dest, rf_writeVal} !== e) begin
               n_bad++;
               $display("FAIL rand_write[%0d]: dest=%0d val=%h, required dest=%0d val=%h",
                        i, rf_dest, rf_writeVal, dest_of(e), data_of(e));
            end
         end
         n_cmp++;
         if (rf_dest !== m_dest || rf_writeVal !== m_val) begin
            n_bad++;
            $display("FAIL rand_hold[%0d]: dest=%0d val=%h, required dest=%0d val=%h",
                     i, rf_dest, rf_writeVal, m_dest, m_val);
         end
`ifdef RF_ARB_STATS_EN
         n_cmp++;
         if (stat_grant_a !== 16'(st_a) || stat_grant_b !== 16'(st_b) || stat_conflict !== 16'(st_c)) begin
            n_bad++;
            $display("FAIL rand_stats[%0d]: ga=%0d gb=%0d c=%0d, required %0d/%0d/%0d",
                     i, stat_grant_a, stat_grant_b, stat_conflict, st_a, st_b, st_c);
         end
`endif
      end
      rst = 1'b0; idle_inputs();
      clock_edge();
   endtask

   // ------------------------------------------------------------ sequence
   initial begin
      wait_m = 0; m_en = 1'b0; m_dest = '0; m_val = '0; gnt = 0;
      st_a = 0; st_b = 0; st_c = 0;
      rst = 1'b1; idle_inputs(); q_src1 = '0; q_src2 = '0;
      test_reset();
      test_a_only();
      test_contention();
      test_aging();
      test_dest_zero();
      test_rst_mid();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
